// File: rtl/cmul_pkg.sv
// cmul_pkg: shared definitions for the complex-multiply sequencing controller.
//   - FSM state codes (IDLE, RR, II, RI, IR, IM)
//   - datapath widths (12-bit operands, 24-bit products)
//   - operand-select and add/subtract encodings
//   - ctrl_t: the select/enable bundle driven towards the datapath
package cmul_pkg;

    localparam int OPND_W = 12;
    localparam int PROD_W = 24;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RR   = 3'd1;  // PP1 <- ar*br
    localparam state_t ST_II   = 3'd2;  // PP2 <- ai*bi
    localparam state_t ST_RI   = 3'd3;  // Pr <- PP1-PP2, PP1 <- ar*bi
    localparam state_t ST_IR   = 3'd4;  // PP2 <- ai*br, operands released
    localparam state_t ST_IM   = 3'd5;  // Pi <- PP1+PP2

    localparam logic SEL_R  = 1'b0;
    localparam logic SEL_I  = 1'b1;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic a_sel;
        logic b_sel;
        logic pp1_ce;
        logic pp2_ce;
        logic add;
        logic pr_ce;
        logic pi_ce;
        logic in_ready;
    } ctrl_t;

endpackage

// File: rtl/cmul_step_decode.sv
// cmul_step_decode: combinational map from controller state to the datapath
// select/enable bundle.
// Ports:
//   state     in   current FSM state
//   in_valid  in   upstream operands valid (only consulted in IM when
//                  CMUL_CTRL_OVERLAP_EN is defined)
//   ctrl      out  select/enable bundle (all zero in IDLE)
// Config macro: CMUL_CTRL_OVERLAP_EN -- IM also performs the next RR step.
module cmul_step_decode
    import cmul_pkg::*;
(
    input  state_t state,
    input  logic   in_valid,
    output ctrl_t  ctrl
);

`ifndef CMUL_CTRL_OVERLAP_EN
    logic unused_in_valid;
    assign unused_in_valid = in_valid;
`endif

    always_comb begin
        ctrl = '0;
        case (state)
            ST_RR: begin
                ctrl.a_sel  = SEL_R;
                ctrl.b_sel  = SEL_R;
                ctrl.pp1_ce = 1'b1;
            end
            ST_II: begin
                ctrl.a_sel  = SEL_I;
                ctrl.b_sel  = SEL_I;
                ctrl.pp2_ce = 1'b1;
            end
            ST_RI: begin
                ctrl.a_sel  = SEL_R;
                ctrl.b_sel  = SEL_I;
                ctrl.pp1_ce = 1'b1;
                ctrl.add    = OP_SUB;
                ctrl.pr_ce  = 1'b1;
            end
            ST_IR: begin
                ctrl.a_sel    = SEL_I;
                ctrl.b_sel    = SEL_R;
                ctrl.pp2_ce   = 1'b1;
                ctrl.in_ready = 1'b1;
            end
            ST_IM: begin
                ctrl.add   = OP_ADD;
                ctrl.pi_ce = 1'b1;
`ifdef CMUL_CTRL_OVERLAP_EN
                // The adder consumes the old PP1 before this edge, so the
                // next operation's ar*br can be captured in the same cycle.
                if (in_valid) begin
                    ctrl.a_sel  = SEL_R;
                    ctrl.b_sel  = SEL_R;
                    ctrl.pp1_ce = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cmul_ctrl.sv
// cmul_ctrl: sequencing controller for a single-multiplier complex multiply
//   Pr = ar*br - ai*bi, Pi = ar*bi + ai*br, in four multiplier steps.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   upstream operand handshake (ready in IR step)
//   out_valid/out_ready downstream Pr/Pi handshake
//   a_sel, b_sel        operand selects (0 = real, 1 = imaginary)
//   pp1_ce, pp2_ce      partial-product register enables
//   add                 0 = PP1+PP2, 1 = PP1-PP2
//   pr_ce, pi_ce        result register enables
//   busy                state != IDLE
//   op_count            completed operations, wraps mod 2^CNT_W
// Config macro: CMUL_CTRL_OVERLAP_EN -- overlap IM with the next RR step
//   (IM -> II) and accept new work in IDLE even while a result is pending.
module cmul_ctrl
    import cmul_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_sel,
    output logic             b_sel,
    output logic             pp1_ce,
    output logic             pp2_ce,
    output logic             add,
    output logic             pr_ce,
    output logic             pi_ce,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t state, state_nxt;
    ctrl_t  ctrl;

    cmul_step_decode u_decode (
        .state    (state),
        .in_valid (in_valid),
        .ctrl     (ctrl)
    );

    assign a_sel    = ctrl.a_sel;
    assign b_sel    = ctrl.b_sel;
    assign pp1_ce   = ctrl.pp1_ce;
    assign pp2_ce   = ctrl.pp2_ce;
    assign add      = ctrl.add;
    assign pr_ce    = ctrl.pr_ce;
    assign pi_ce    = ctrl.pi_ce;
    assign in_ready = ctrl.in_ready;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
`ifdef CMUL_CTRL_OVERLAP_EN
                // A pending result is protected by the II stall below.
                if (in_valid) state_nxt = ST_RR;
`else
                if (in_valid && !out_valid) state_nxt = ST_RR;
`endif
            end
            ST_RR: state_nxt = ST_II;
            // RI overwrites Pr, so hold here until the old result is gone
            // or leaves this cycle. Re-capturing PP2 meanwhile is harmless.
            ST_II: if (!out_valid || out_ready) state_nxt = ST_RI;
            ST_RI: state_nxt = ST_IR;
            ST_IR: state_nxt = ST_IM;
            ST_IM: begin
`ifdef CMUL_CTRL_OVERLAP_EN
                state_nxt = in_valid ? ST_II : ST_IDLE;
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            state <= state_nxt;
            // Setting on the IM edge has priority over the sink's accept.
            if (state == ST_IM) begin
                out_valid <= 1'b1;
                op_count  <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
